// File: rtl/key_pkg.sv
// Shared types and default timing for the key debounce block.
// The default timing constants assume a 50 MHz system clock.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_FLT = 2'd1,
    DOWN      = 2'd2,
    REL_FLT   = 2'd3
  } key_state_e;

  localparam int TIME_20MS_50M = 1_000_000;
  localparam int TIME_LONG_50M = 50_000_000;

endpackage

// File: rtl/key_filter.sv
// One key channel: two-flop synchroniser, debounce/hold FSM with a shared
// counter, and registered level, press, release and long-press outputs.
module key_filter
  import key_pkg::*;
#(
  parameter int TIME_20MS = TIME_20MS_50M,
  parameter int TIME_LONG = TIME_LONG_50M
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int                CNT_W    = $clog2(TIME_LONG);
  localparam logic [CNT_W-1:0]  FLT_END  = CNT_W'(TIME_20MS - 1);
  localparam logic [CNT_W-1:0]  LONG_END = CNT_W'(TIME_LONG - 1);

  logic [1:0]       sync_q;
  logic             s;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             long_done_q, long_done_d;
  logic             ev_press_q, ev_press_d;
  logic             ev_release_q, ev_release_d;
  logic             ev_long_q, ev_long_d;
  logic             level_q, press_q, release_q, long_q;

  assign s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= 2'b11;
      state_q      <= IDLE;
      cnt_q        <= '0;
      long_done_q  <= 1'b0;
      ev_press_q   <= 1'b0;
      ev_release_q <= 1'b0;
      ev_long_q    <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], key_i};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      long_done_q  <= long_done_d;
      ev_press_q   <= ev_press_d;
      ev_release_q <= ev_release_d;
      ev_long_q    <= ev_long_d;
    end
  end

  // The counter times both the bounce window and the hold; it parks at
  // LONG_END once the long pulse has fired, so long_done_q blocks repeats.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    long_done_d  = long_done_q;
    ev_press_d   = 1'b0;
    ev_release_d = 1'b0;
    ev_long_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!s) begin
          state_d = PRESS_FLT;
          cnt_d   = '0;
        end
      end
      PRESS_FLT: begin
        if (s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == FLT_END) begin
          state_d     = DOWN;
          cnt_d       = '0;
          long_done_d = 1'b0;
          ev_press_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOWN: begin
        if (s) begin
          state_d = REL_FLT;
          cnt_d   = '0;
        end else if (cnt_q == LONG_END) begin
          ev_long_d   = !long_done_q;
          long_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REL_FLT: begin
        if (!s) begin
          state_d     = DOWN;
          cnt_d       = '0;
          long_done_d = 1'b0;
        end else if (cnt_q == FLT_END) begin
          state_d      = IDLE;
          cnt_d        = '0;
          ev_release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register stage: level and press rise on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      level_q   <= (state_q == DOWN) || (state_q == REL_FLT);
      press_q   <= ev_press_q;
      release_q <= ev_release_q;
      long_q    <= ev_long_q;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button conditioner: one independent key_filter per
// active-low key input, with the vectors sliced per channel.
module key_debounce
  import key_pkg::*;
#(
  parameter int KEY_W     = 4,
  parameter int TIME_20MS = TIME_20MS_50M,
  parameter int TIME_LONG = TIME_LONG_50M
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long
);

  for (genvar g = 0; g < KEY_W; g++) begin : g_key
    key_filter #(
      .TIME_20MS (TIME_20MS),
      .TIME_LONG (TIME_LONG)
    ) u_filter (
      .clk       (clk),
      .rst       (rst),
      .key_i     (key_in[g]),
      .level_o   (key_level[g]),
      .press_o   (key_press[g]),
      .release_o (key_release[g]),
      .long_o    (key_long[g])
    );
  end

endmodule
